// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants and helpers for the four-digit seven-segment scanner.
// Anode patterns are active-low.
package seven_seg_scanner_pkg;

   localparam logic [3:0] AN_OFF              = 4'b1111;
   localparam int         NUM_DIGITS          = 4;
   localparam int         DEFAULT_REFRESH_DIV = 50000;

   typedef logic [1:0] digit_idx_t;
   typedef logic [3:0] nibble_t;

   function automatic nibble_t nibble_of(input logic [15:0] v, input digit_idx_t i);
      nibble_t n;
      case (i)
         2'd0:    n = v[3:0];
         2'd1:    n = v[7:4];
         2'd2:    n = v[11:8];
         default: n = v[15:12];
      endcase
      return n;
   endfunction

   // Digit i is a leading zero when every nibble from i upward is zero; digit 0 always shows.
   function automatic logic [3:0] lz_blank_mask(input logic [15:0] v);
      logic [3:0] m;
      m[3] = (v[15:12] == 4'h0);
      m[2] = (v[15:8]  == 8'h00);
      m[1] = (v[15:4]  == 12'h000);
      m[0] = 1'b0;
      return m;
   endfunction

   function automatic logic [3:0] anode_sel(input digit_idx_t i);
      logic [3:0] a;
      case (i)
         2'd0:    a = 4'b1110;
         2'd1:    a = 4'b1101;
         2'd2:    a = 4'b1011;
         default: a = 4'b0111;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Datapath-side load port and display-side scan outputs of the scanner.
interface seven_seg_scanner_if;
   import seven_seg_scanner_pkg::*;

   logic [15:0] data_in;
   logic        load;
   logic        blank_lz;
   nibble_t     hex_out;
   logic [3:0]  an;
   digit_idx_t  digit_idx;

   modport master (
      output data_in, load, blank_lz,
      input  hex_out, an, digit_idx
   );

   modport slave (
      input  data_in, load, blank_lz,
      output hex_out, an, digit_idx
   );

endinterface

// File: rtl/seven_seg_scanner_refresh_tick.sv
// Modulo-DIV slot counter: cnt_zero marks the guard cycle, wrap marks the last cycle of a slot.
module refresh_tick #(
   parameter int DIV = 4
) (
   input  logic clk,
   input  logic reset,
   output logic cnt_zero,
   output logic wrap
);

   localparam int             CW   = $clog2(DIV);
   localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign cnt_zero = (cnt == '0);
   assign wrap     = (cnt == LAST);

endmodule

// File: rtl/seven_seg_scanner.sv
// Latches a 16-bit value and scans its nibbles onto a 4-digit common-anode display.
// All outputs are registered one cycle behind the value/index/counter state.
module seven_seg_scanner
   import seven_seg_scanner_pkg::*;
#(
   parameter int REFRESH_DIV = DEFAULT_REFRESH_DIV
) (
   input  logic               clk,
   input  logic               reset,
   seven_seg_scanner_if.slave bus
);

   logic [15:0] value;
   digit_idx_t  idx;
   logic        cnt_zero;
   logic        wrap;
   logic [3:0]  blank_mask;
   logic [3:0]  an_next;

   refresh_tick #(
      .DIV (REFRESH_DIV)
   ) u_tick (
      .clk      (clk),
      .reset    (reset),
      .cnt_zero (cnt_zero),
      .wrap     (wrap)
   );

   // Guard cycle at the start of each slot keeps the previous digit's anode from overlapping the new nibble.
   always_comb begin
      blank_mask = '0;
      an_next    = AN_OFF;
      if (bus.blank_lz) begin
         blank_mask = lz_blank_mask(value);
      end
      if (!cnt_zero && !blank_mask[idx]) begin
         an_next = anode_sel(idx);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         value         <= 16'h0000;
         idx           <= 2'd0;
         bus.hex_out   <= 4'h0;
         bus.an        <= AN_OFF;
         bus.digit_idx <= 2'd0;
      end else begin
         if (bus.load) begin
            value <= bus.data_in;
         end
         if (wrap) begin
            idx <= idx + 2'd1;
         end
         bus.hex_out   <= nibble_of(value, idx);
         bus.an        <= an_next;
         bus.digit_idx <= idx;
      end
   end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed and random scan checks of seven_seg_scanner against a cycle-count reference model.
module tb_seven_seg_scanner;

   localparam int DIV   = 4;
   localparam int FRAME = 4 * DIV;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   seven_seg_scanner_if bus ();

   seven_seg_scanner #(
      .REFRESH_DIV (DIV)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int          checks = 0;
   int          errors = 0;
   int          m_t    = 0;       // edges since reset released
   logic [15:0] m_val  = 16'h0;
   logic [3:0]  e_hex;
   logic [3:0]  e_an;
   logic [3:0]  e_idx;
   logic        cur_blank = 1'b0;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, advance the model with the pre-edge state, compare just after the edge.
   task automatic step(input logic rst, input logic ld, input logic [15:0] d, input logic bl);
      int pos;
      int dig;
      reset        = rst;
      bus.load     = ld;
      bus.data_in  = d;
      bus.blank_lz = bl;
      @(posedge clk);
      if (rst) begin
         e_hex = 4'h0;
         e_an  = 4'hF;
         e_idx = 4'h0;
         m_t   = 0;
         m_val = 16'h0;
      end else begin
         pos   = m_t % DIV;
         dig   = (m_t / DIV) % 4;
         e_hex = 4'((m_val >> (4 * dig)) & 16'hF);
         e_idx = 4'(dig);
         if (pos == 0 || (bl && dig != 0 && (m_val >> (4 * dig)) == 16'h0))
            e_an = 4'hF;
         else
            e_an = 4'hF ^ 4'(1 << dig);
         if (ld) m_val = d;
         m_t++;
      end
      #1;
      chk("hex_out", bus.hex_out, e_hex);
      chk("an", bus.an, e_an);
      chk("digit_idx", {2'b00, bus.digit_idx}, e_idx);
      chk("an_onehot", {3'b000, ($countones(~bus.an) <= 1)}, 4'h1);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0, cur_blank);
   endtask

   task automatic run_to(input int phase);
      for (int k = 0; k < 2 * FRAME && (m_t % FRAME) != phase; k++)
         step(1'b0, 1'b0, 16'h0, cur_blank);
      chk("run_to_phase", 4'(m_t % FRAME), 4'(phase));
   endtask

   initial begin
      reset        = 1'b1;
      bus.load     = 1'b0;
      bus.data_in  = 16'h0;
      bus.blank_lz = 1'b0;

      step(1'b1, 1'b0, 16'h0, 1'b0);
      step(1'b1, 1'b0, 16'h0, 1'b0);

      // Idle after reset: guard first, then digit 0 lights on the second edge.
      step(1'b0, 1'b0, 16'h0, 1'b0);
      chk("first_guard", bus.an, 4'b1111);
      step(1'b0, 1'b0, 16'h0, 1'b0);
      chk("first_active", bus.an, 4'b1110);
      idle(14);

      // BEEF without blanking, full frame plus one.
      cur_blank = 1'b0;
      run_to(FRAME - 1);
      step(1'b0, 1'b1, 16'hBEEF, 1'b0);
      idle(FRAME + 2);

      // 002A with blanking: upper digits dark.
      cur_blank = 1'b1;
      step(1'b0, 1'b1, 16'h002A, 1'b1);
      idle(FRAME + 2);

      // 0000 with blanking: only digit 0.
      step(1'b0, 1'b1, 16'h0000, 1'b1);
      idle(FRAME + 2);

      // Load coincident with slot 0 -> 1 wrap.
      cur_blank = 1'b0;
      step(1'b0, 1'b1, 16'h1234, 1'b0);
      run_to(DIV - 1);
      step(1'b0, 1'b1, 16'h5678, 1'b0);
      step(1'b0, 1'b0, 16'h0, 1'b0);
      step(1'b0, 1'b0, 16'h0, 1'b0);
      chk("coinc_hex", bus.hex_out, 4'h7);
      chk("coinc_an", bus.an, 4'b1101);
      idle(4);

      // Reset in the middle of slot 2 after loading FFFF.
      step(1'b0, 1'b1, 16'hFFFF, 1'b0);
      run_to(2 * DIV + 1);
      step(1'b1, 1'b0, 16'h0, 1'b0);
      chk("rst_an", bus.an, 4'b1111);
      chk("rst_hex", bus.hex_out, 4'h0);
      step(1'b0, 1'b0, 16'h0, 1'b0);
      step(1'b0, 1'b0, 16'h0, 1'b0);
      chk("restart_an", bus.an, 4'b1110);
      chk("restart_hex", bus.hex_out, 4'h0);
      idle(6);

      // Random loads, blank_lz toggling and occasional resets.
      for (int k = 0; k < 400; k++) begin
         logic        r_rst;
         logic        r_ld;
         logic [15:0] r_d;
         logic        r_bl;
         r_rst = ($urandom_range(0, 63) == 0);
         r_ld  = ($urandom_range(0, 5) == 0);
         r_d   = 16'($urandom);
         if ($urandom_range(0, 1) == 0) r_d[15:8] = 8'h00;
         r_bl  = 1'($urandom_range(0, 1));
         step(r_rst, r_ld, r_d, r_bl);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
